// File: rtl/alu_bist.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : alu_bist
//  Purpose  : Built-in self-test sequencer for a 32-bit ALU. On start it
//             latches two seeds and walks 15 vectors (3 operand pairs x 5
//             operations). For each vector it drives operands and an op code,
//             waits SETTLE cycles, and then compares the ALU result and zero
//             flag against a locally computed reference.
//  Ports    : clk          - rising-edge clock
//             rst          - asynchronous reset, active low
//             start        - one-cycle run request, honoured only in IDLE
//             seed_a/b     - operand seeds, captured when a run is accepted
//             alu_result   - result returned by the ALU under test
//             alu_zero     - zero flag returned by the ALU under test
//             alu_a/b      - registered operands driven to the ALU
//             alu_control  - registered ALU op code
//             busy         - run in progress
//             done         - one-cycle completion pulse
//             pass         - last run had no mismatches
//             fail_count   - mismatching vectors in last run
//             first_fail   - index of first mismatching vector (F = none)
//  Revision : 1.0 - initial release
// ============================================================================
module alu_bist #(
  parameter int SETTLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] seed_a,
  input  logic [31:0] seed_b,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_control,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [3:0]  fail_count,
  output logic [3:0]  first_fail
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_FINISH = 3'd4
  } state_t;

  localparam logic [3:0] LAST_VEC     = 4'd14;
  localparam logic [3:0] NO_FAIL      = 4'hF;
  localparam logic [2:0] LAST_OP      = 3'd4;
  // Cycles spent in SETTLE beyond the one that DRIVE->CHECK always costs.
  localparam logic [3:0] SETTLE_EXTRA = 4'(SETTLE - 1);

  state_t      state_q, state_d;
  logic [31:0] seed_a_q, seed_a_d;
  logic [31:0] seed_b_q, seed_b_d;
  logic [1:0]  pair_q, pair_d;
  logic [2:0]  op_q, op_d;
  logic [3:0]  wait_q, wait_d;
  logic [31:0] alu_a_q, alu_a_d;
  logic [31:0] alu_b_q, alu_b_d;
  logic [2:0]  alu_control_q, alu_control_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic [3:0]  fail_count_q, fail_count_d;
  logic [3:0]  first_fail_q, first_fail_d;

  logic [31:0] exp_result;
  logic        exp_zero;
  logic        mismatch;
  logic [3:0]  vec_idx;

  // Op position within a pair -> ALU op code (AND, OR, ADD, SUB, SLT).
  function automatic logic [2:0] op_code(input logic [2:0] pos);
    case (pos)
      3'd0:    op_code = 3'b000;
      3'd1:    op_code = 3'b001;
      3'd2:    op_code = 3'b010;
      3'd3:    op_code = 3'b110;
      default: op_code = 3'b111;
    endcase
  endfunction

  // Reference is computed from the registered drive values so it always
  // describes exactly what the ALU is currently seeing.
  always_comb begin
    exp_result = 32'd0;
    case (alu_control_q)
      3'b000:  exp_result = alu_a_q & alu_b_q;
      3'b001:  exp_result = alu_a_q | alu_b_q;
      3'b010:  exp_result = alu_a_q + alu_b_q;
      3'b110:  exp_result = alu_a_q - alu_b_q;
      3'b111:  exp_result = {31'd0, ($signed(alu_a_q) < $signed(alu_b_q))};
      default: exp_result = 32'd0;
    endcase
  end

  assign exp_zero = (exp_result == 32'd0);
  assign mismatch = (alu_result != exp_result) || (alu_zero != exp_zero);
  // pair*5 + op, built from shifts so no multiplier is implied.
  assign vec_idx  = {pair_q, 2'b00} + {2'b00, pair_q} + {1'b0, op_q};

  always_comb begin
    state_d       = state_q;
    seed_a_d      = seed_a_q;
    seed_b_d      = seed_b_q;
    pair_d        = pair_q;
    op_d          = op_q;
    wait_d        = wait_q;
    alu_a_d       = alu_a_q;
    alu_b_d       = alu_b_q;
    alu_control_d = alu_control_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    pass_d        = pass_q;
    fail_count_d  = fail_count_q;
    first_fail_d  = first_fail_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          seed_a_d     = seed_a;
          seed_b_d     = seed_b;
          pair_d       = 2'd0;
          op_d         = 3'd0;
          fail_count_d = 4'd0;
          first_fail_d = NO_FAIL;
          pass_d       = 1'b0;
          busy_d       = 1'b1;
          state_d      = ST_DRIVE;
        end
      end

      ST_DRIVE: begin
        // Pair 0 = (A,B), pair 1 = (B,A), pair 2 = (A,A).
        alu_a_d       = (pair_q == 2'd1) ? seed_b_q : seed_a_q;
        alu_b_d       = (pair_q == 2'd0) ? seed_b_q : seed_a_q;
        alu_control_d = op_code(op_q);
        wait_d        = SETTLE_EXTRA;
        state_d       = (SETTLE_EXTRA != 4'd0) ? ST_SETTLE : ST_CHECK;
      end

      ST_SETTLE: begin
        if (wait_q <= 4'd1) begin
          state_d = ST_CHECK;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end

      ST_CHECK: begin
        if (mismatch) begin
          fail_count_d = fail_count_q + 4'd1;
          if (first_fail_q == NO_FAIL) begin
            first_fail_d = vec_idx;
          end
        end
        if (vec_idx == LAST_VEC) begin
          state_d = ST_FINISH;
        end else begin
          state_d = ST_DRIVE;
          if (op_q == LAST_OP) begin
            op_d   = 3'd0;
            pair_d = pair_q + 2'd1;
          end else begin
            op_d = op_q + 3'd1;
          end
        end
      end

      ST_FINISH: begin
        // start is deliberately not sampled here; it is honoured next IDLE.
        done_d  = 1'b1;
        pass_d  = (fail_count_q == 4'd0);
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      seed_a_q      <= 32'd0;
      seed_b_q      <= 32'd0;
      pair_q        <= 2'd0;
      op_q          <= 3'd0;
      wait_q        <= 4'd0;
      alu_a_q       <= 32'd0;
      alu_b_q       <= 32'd0;
      alu_control_q <= 3'b000;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      fail_count_q  <= 4'd0;
      first_fail_q  <= NO_FAIL;
    end else begin
      state_q       <= state_d;
      seed_a_q      <= seed_a_d;
      seed_b_q      <= seed_b_d;
      pair_q        <= pair_d;
      op_q          <= op_d;
      wait_q        <= wait_d;
      alu_a_q       <= alu_a_d;
      alu_b_q       <= alu_b_d;
      alu_control_q <= alu_control_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      fail_count_q  <= fail_count_d;
      first_fail_q  <= first_fail_d;
    end
  end

  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_control = alu_control_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign fail_count  = fail_count_q;
  assign first_fail  = first_fail_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_bist.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_alu_bist
//  Purpose  : Self-checking bench for alu_bist. Two instances: SETTLE=1 with
//             a configurable ALU model (correct / OR-as-AND / unsigned SLT /
//             2-cycle latency) and SETTLE=3 with a 2-cycle-latency ALU.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_alu_bist;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start1, start3;
  logic [31:0] seed_a, seed_b;
  logic [31:0] a1, b1, res1, a3, b3, res3;
  logic [2:0]  c1, c3;
  logic        z1, z3, busy1, busy3, done1, done3, pass1, pass3;
  logic [3:0]  fc1, fc3, ff1, ff3;
  logic [31:0] p1a, p1b, p3a, p3b;

  int fault_mode = 0;
  bit lat1       = 1'b0;
  int cyc        = 0;
  int checks     = 0;
  int failures   = 0;
  int busy_cnt1  = 0;
  int busy_cnt3  = 0;

  typedef struct {
    int          dut;
    int          t0;
    int          settle;
    logic [31:0] sa;
    logic [31:0] sb;
    bit          exact;
    logic        pass;
    logic [3:0]  fc;
    logic [3:0]  ff;
  } exp_t;

  exp_t q[$];

  localparam logic [2:0] OPS [5] = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_bist #(.SETTLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .seed_a(seed_a), .seed_b(seed_b),
    .alu_result(res1), .alu_zero(z1), .alu_a(a1), .alu_b(b1), .alu_control(c1),
    .busy(busy1), .done(done1), .pass(pass1), .fail_count(fc1), .first_fail(ff1)
  );

  alu_bist #(.SETTLE(3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .seed_a(seed_a), .seed_b(seed_b),
    .alu_result(res3), .alu_zero(z3), .alu_a(a3), .alu_b(b3), .alu_control(c3),
    .busy(busy3), .done(done3), .pass(pass3), .fail_count(fc3), .first_fail(ff3)
  );

  // ALU under test: mode 0 correct, 1 OR behaves as AND, 2 SLT unsigned.
  function automatic logic [31:0] alu_model(input logic [31:0] x, input logic [31:0] y,
                                            input logic [2:0] ctl, input int mode);
    case (ctl)
      3'b000: return x & y;
      3'b001: return (mode == 1) ? (x & y) : (x | y);
      3'b010: return x + y;
      3'b110: return x - y;
      3'b111: begin
        if (mode == 2) return (x < y) ? 32'd1 : 32'd0;
        else           return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      end
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  always @(posedge clk) begin
    p1a <= alu_model(a1, b1, c1, fault_mode);
    p1b <= p1a;
    p3a <= alu_model(a3, b3, c3, fault_mode);
    p3b <= p3a;
  end

  assign res1 = lat1 ? p1b : alu_model(a1, b1, c1, fault_mode);
  assign res3 = p3b;
  assign z1   = (res1 == 32'd0);
  assign z3   = (res3 == 32'd0);

  // Reference: what a correct ALU returns for op position o.
  function automatic logic [31:0] ideal(input logic [31:0] x, input logic [31:0] y, input int o);
    longint sx, sy, ux, uy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'({32'd0, x});
    uy = longint'({32'd0, y});
    case (o)
      0:       return x & y;
      1:       return x | y;
      2:       return 32'((ux + uy) % 64'sd4294967296);
      3:       return 32'((ux - uy + 64'sd4294967296) % 64'sd4294967296);
      default: return (sx < sy) ? 32'd1 : 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] opnd_x(input int p, input logic [31:0] sa, input logic [31:0] sb);
    return (p == 1) ? sb : sa;
  endfunction

  function automatic logic [31:0] opnd_y(input int p, input logic [31:0] sa, input logic [31:0] sb);
    return (p == 0) ? sb : sa;
  endfunction

  function automatic exp_t build(input int dut, input int t0, input logic [31:0] sa,
                                 input logic [31:0] sb, input int mode, input bit lat);
    exp_t e;
    logic [31:0] x, y;
    e.dut    = dut;
    e.t0     = t0;
    e.settle = (dut == 1) ? 1 : 3;
    e.sa     = sa;
    e.sb     = sb;
    e.fc     = 4'd0;
    e.ff     = 4'hF;
    for (int k = 0; k < 15; k++) begin
      x = opnd_x(k / 5, sa, sb);
      y = opnd_y(k / 5, sa, sb);
      if (alu_model(x, y, OPS[k % 5], mode) !== ideal(x, y, k % 5)) begin
        e.fc = e.fc + 4'd1;
        if (e.ff == 4'hF) e.ff = 4'(k);
      end
    end
    // A latent ALU at SETTLE=1 returns stale results; only pass=0 is defined.
    e.exact = !(lat && dut == 1);
    e.pass  = e.exact && (e.fc == 4'd0);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_rst(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] c, input logic bz, input logic dn, input logic ps,
                         input logic [3:0] fc, input logic [3:0] ff);
    chk({tag, "_alu_a"}, a, 32'd0);
    chk({tag, "_alu_b"}, b, 32'd0);
    chk({tag, "_alu_control"}, 32'(c), 32'd0);
    chk({tag, "_busy"}, 32'(bz), 32'd0);
    chk({tag, "_done"}, 32'(dn), 32'd0);
    chk({tag, "_pass"}, 32'(ps), 32'd0);
    chk({tag, "_fail_count"}, 32'(fc), 32'd0);
    chk({tag, "_first_fail"}, 32'(ff), 32'hF);
  endtask

  task automatic check_drive(input exp_t e);
    int off, per, k;
    logic [31:0] aa, bb;
    logic [2:0]  cc;
    off = cyc - e.t0;
    per = e.settle + 1;
    if (off >= 1 && ((off - 1) % per) == 0 && ((off - 1) / per) < 15) begin
      k  = (off - 1) / per;
      aa = (e.dut == 1) ? a1 : a3;
      bb = (e.dut == 1) ? b1 : b3;
      cc = (e.dut == 1) ? c1 : c3;
      chk($sformatf("vec%0d_alu_a", k), aa, opnd_x(k / 5, e.sa, e.sb));
      chk($sformatf("vec%0d_alu_b", k), bb, opnd_y(k / 5, e.sa, e.sb));
      chk($sformatf("vec%0d_alu_control", k), 32'(cc), 32'(OPS[k % 5]));
    end
  endtask

  task automatic check_done();
    exp_t e;
    int d;
    d = (done1 === 1'b1) ? 1 : 3;
    if (q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL spurious_done: dut%0d pulsed done, required no pulse", d);
      return;
    end
    e = q.pop_front();
    chk("done_dut", 32'(d), 32'(e.dut));
    chk("done_latency", 32'(cyc - e.t0), 32'(15 * (e.settle + 1) + 1));
    chk("busy_cycles", 32'((d == 1) ? busy_cnt1 : busy_cnt3), 32'(15 * (e.settle + 1) + 1));
    chk("busy_at_done", 32'((d == 1) ? busy1 : busy3), 32'd0);
    chk("pass", 32'((d == 1) ? pass1 : pass3), 32'(e.pass));
    chk("hold_alu_control", 32'((d == 1) ? c1 : c3), 32'h7);
    chk("hold_alu_a", (d == 1) ? a1 : a3, e.sa);
    chk("hold_alu_b", (d == 1) ? b1 : b3, e.sa);
    if (e.exact) begin
      chk("fail_count", 32'((d == 1) ? fc1 : fc3), 32'(e.fc));
      chk("first_fail", 32'((d == 1) ? ff1 : ff3), 32'(e.ff));
    end
    if (d == 1) busy_cnt1 = 0;
    else        busy_cnt3 = 0;
  endtask

  // Monitor / scoreboard checker.
  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      #1;
      busy_cnt1 = 0;
      busy_cnt3 = 0;
      chk_rst("rst1", a1, b1, c1, busy1, done1, pass1, fc1, ff1);
      chk_rst("rst3", a3, b3, c3, busy3, done3, pass3, fc3, ff3);
    end else begin
      if (busy1 === 1'b1) busy_cnt1++;
      if (busy3 === 1'b1) busy_cnt3++;
      if (q.size() > 0) check_drive(q[0]);
      if (done1 === 1'b1 || done3 === 1'b1) check_done();
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic issue(input int dut, input logic [31:0] sa, input logic [31:0] sb,
                       input int mode, input bit lat);
    @(negedge clk);
    seed_a     = sa;
    seed_b     = sb;
    fault_mode = mode;
    lat1       = (dut == 1) ? lat : 1'b0;
    if (dut == 1) start1 = 1'b1;
    else          start3 = 1'b1;
    q.push_back(build(dut, cyc + 1, sa, sb, mode, lat));
    @(negedge clk);
    start1 = 1'b0;
    start3 = 1'b0;
    // Seeds wander during the run; the run must keep its latched copies.
    seed_a = $urandom;
    seed_b = $urandom;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (q.size() != 0) begin
      @(negedge clk);
      n++;
      if (n > 500) begin
        $display("FAIL run_timeout: no done after %0d cycles, required done", n);
        $fatal(1, "run timeout");
      end
    end
  endtask

  task automatic run(input int dut, input logic [31:0] sa, input logic [31:0] sb,
                     input int mode, input bit lat);
    issue(dut, sa, sb, mode, lat);
    wait_idle();
  endtask

  initial begin
    int t0;
    start1 = 1'b0;
    start3 = 1'b0;
    seed_a = 32'd0;
    seed_b = 32'd0;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;

    run(1, 32'd10, 32'd7, 0, 1'b0);
    run(1, 32'd10, 32'd7, 1, 1'b0);
    run(1, 32'h8000_0000, 32'd1, 2, 1'b0);
    for (int i = 0; i < 6; i++) begin
      run(1, $urandom, $urandom, int'($urandom_range(0, 2)), 1'b0);
    end

    // start held high across a whole run: FINISH ignores it, next IDLE takes it.
    @(negedge clk);
    seed_a     = $urandom;
    seed_b     = $urandom;
    fault_mode = 0;
    lat1       = 1'b0;
    start1     = 1'b1;
    t0         = cyc + 1;
    q.push_back(build(1, t0, seed_a, seed_b, 0, 1'b0));
    @(negedge clk);
    seed_a = $urandom;
    seed_b = $urandom;
    while (cyc < t0 + 31) @(negedge clk);
    q.push_back(build(1, t0 + 32, seed_a, seed_b, 0, 1'b0));
    @(negedge clk);
    start1 = 1'b0;
    wait_idle();

    // Reset in the middle of a run aborts it; a fresh run then completes.
    issue(1, $urandom, $urandom, 0, 1'b0);
    repeat (11) @(negedge clk);
    #2 rst = 1'b0;
    q.delete();
    @(negedge clk);
    rst = 1'b1;
    run(1, 32'd10, 32'd7, 0, 1'b0);

    // Latent ALU: passes with SETTLE=3, fails with SETTLE=1.
    run(3, $urandom, $urandom, 0, 1'b1);
    run(3, 32'd10, 32'd7, 0, 1'b1);
    run(1, 32'd10, 32'd7, 0, 1'b1);
    lat1 = 1'b0;

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_bist.md
ALU_BIST -- requirements
Module: alu_bist

Interface
REQ-001 Parameter SETTLE, default 1, sets the cycles from driving a vector to sampling the ALU response; legal range 1-15.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  reset: asynchronous assert, active-low (0 = reset).
REQ-004 start  input  1  single-cycle request to begin a self-test run; sampled only in IDLE.
REQ-005 seed_a  input  32  operand A seed, latched on an accepted start.
REQ-006 seed_b  input  32  operand B seed, latched on an accepted start.
REQ-007 alu_result  input  32  result returned by the ALU under test.
REQ-008 alu_zero  input  1  zero flag returned by the ALU under test.
REQ-009 alu_a  output  32  registered operand A driven to the ALU.
REQ-010 alu_b  output  32  registered operand B driven to the ALU.
REQ-011 alu_control  output  3  registered ALU operation code.
REQ-012 busy  output  1  high from the cycle after an accepted start until done.
REQ-013 done  output  1  one-cycle pulse when a run completes.
REQ-014 pass  output  1  high after a run with zero mismatches; held until the next accepted start.
REQ-015 fail_count  output  4  number of mismatching vectors in the last run (0-15).
REQ-016 first_fail  output  4  index of the first mismatching vector; 4'hF if none.

Function
REQ-017 Operation codes under test, in this order: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT (signed less-than; result 32'd1 or 32'd0); codes 011, 100, 101 are never driven.
REQ-018 Operand pairs, in this order: pair 0 (A,B), pair 1 (B,A), pair 2 (A,A), where A = seed_a and B = seed_b as latched.
REQ-019 Vector index = pair*5 + op position, giving vectors 0-14; the outer loop is pair and the inner loop is op.
REQ-020 ADD and SUB wrap modulo 2^32; no overflow is reported.
REQ-021 Expected zero flag = (expected result == 32'd0).
REQ-022 States: IDLE, DRIVE, SETTLE, CHECK, FINISH.
REQ-023 IDLE: on start=1, latch the seeds, clear fail_count, set first_fail=4'hF, clear pass, go to DRIVE.
REQ-024 DRIVE: register alu_a, alu_b and alu_control for the current vector; go to SETTLE.
REQ-025 SETTLE: wait SETTLE-1 further cycles (0 extra when SETTLE=1); go to CHECK.
REQ-026 CHECK: compare alu_result and alu_zero against the expected values computed from the registered alu_a, alu_b and alu_control.
REQ-027 On a CHECK mismatch, increment fail_count; if first_fail is 4'hF, load it with the vector index.
REQ-028 After CHECK, go to DRIVE if the vector index is below 14, otherwise go to FINISH.
REQ-029 FINISH: assert done for one cycle, set pass = (fail_count == 0), deassert busy, return to IDLE.
REQ-030 Run latency from the accepted start to the done pulse = 15*(SETTLE+1)+1 cycles; 31 cycles at SETTLE=1.
REQ-031 start while busy is ignored and does not restart the run.
REQ-032 start coincident with FINISH is ignored; start is accepted from the next IDLE cycle.
REQ-033 alu_a, alu_b and alu_control hold their last values in IDLE.
REQ-034 Seed changes during a run have no effect on that run.

Reset
REQ-035 rst=0 asynchronously forces IDLE and the following output values: alu_a=0, alu_b=0, alu_control=000, busy=0, done=0, pass=0, fail_count=0, first_fail=4'hF.
REQ-036 Reset asserted mid-run aborts the run without a done pulse; the first rising clk edge after rst returns to 1 may accept start.

Verification
REQ-037 Correct ALU, seeds 10/7, SETTLE=1 -> expected vector results in order: pair 0 = 2, 15, 17, 3, 0; pair 1 = 2, 15, 17, 32'hFFFFFFFD, 1; pair 2 = 10, 10, 20, 0 (zero=1), 0; done at cycle 31; pass=1, fail_count=0, first_fail=F.
REQ-038 ALU model with OR stuck at AND -> mismatches at vectors 1 and 6 only (pair 2 OR equals AND); fail_count=2, first_fail=1, pass=0.
REQ-039 Seeds 32'h8000_0000 and 1 -> pair 0 SLT=1 and pair 1 SLT=0 (signed); an ALU model using unsigned compare gives fail_count=2, first_fail=4.
REQ-040 Reset pulsed at cycle 12 of a run -> all outputs at their reset values within the same cycle, no done pulse; a new start then completes in 31 cycles.
REQ-041 start held high for the entire run -> exactly one run and one done pulse, with the next run beginning on the cycle after FINISH.
REQ-042 SETTLE=3 with an ALU model adding 2 cycles of registered latency -> pass=1 and done at cycle 61; the same model with SETTLE=1 -> pass=0.
